// File: rtl/sha256_pkg.sv
// SHA-256 constants, working-variable record and the round helper functions
// shared by the round controller and its combinational datapath.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    // Word order matches hash_in/digest: a in the top word, h in the bottom word.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam work_t H_IV = '{
        a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
        e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Word-wise modulo-2^32 sum used for the feed-forward into the digest.
    function automatic work_t add_work(input work_t x, input work_t y);
        work_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        r.f = x.f + y.f;
        r.g = x.g + y.g;
        r.h = x.h + y.h;
        return r;
    endfunction

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Start/busy/done handshake plus block, chaining-value and digest buses.
interface sha256_round_ctrl_if;
    logic         start;
    logic [511:0] block_in;
    logic [255:0] hash_in;
    logic         busy;
    logic         done;
    logic [5:0]   round_idx;
    logic [255:0] digest;

    modport master (
        output start, block_in, hash_in,
        input  busy, done, round_idx, digest
    );

    modport slave (
        input  start, block_in, hash_in,
        output busy, done, round_idx, digest
    );
endinterface

// File: rtl/sha256_round_datapath.sv
// One SHA-256 round, purely combinational: T1/T2 and the rotated working set.
module sha256_round_datapath
    import sha256_pkg::*;
(
    input  work_t       cur,
    input  logic [31:0] k,
    input  logic [31:0] w,
    output logic [31:0] t1,
    output logic [31:0] t2,
    output work_t       nxt
);

    always_comb begin
        t1  = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
        t2  = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
        nxt = '{a: t1 + t2, b: cur.a, c: cur.b, d: cur.c,
                e: cur.d + t1, f: cur.e, g: cur.f, h: cur.g};
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: FSM, round counter, 16-word schedule window,
// chaining-value capture and the final feed-forward add into the digest.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input logic                clk,
    input logic                rst_n,
    sha256_round_ctrl_if.slave bus
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_t      state;
    state_t      state_nx;
    work_t       work;
    work_t       work_nx;
    work_t       h_cap;
    work_t       digest_q;
    logic [31:0] w [16];
    logic [31:0] w_new;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [5:0]  round_idx;
    logic        done_q;
    logic        last_round;
    logic        unused_temps;

    assign last_round = (state == ROUND) && (round_idx == LAST_IDX);
    assign w_new      = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];

    sha256_round_datapath u_datapath (
        .cur (work),
        .k   (K[round_idx]),
        .w   (w[0]),
        .t1  (t1),
        .t2  (t2),
        .nxt (work_nx)
    );

    // T1/T2 are folded into work_nx; kept on the datapath boundary for probing.
    assign unused_temps = ^{t1, t2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = ROUND;
            ROUND:   if (last_round) state_nx = FINAL;
            FINAL:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = done_q;
        bus.round_idx = round_idx;
        bus.digest    = digest_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work      <= '0;
            h_cap     <= '0;
            digest_q  <= '0;
            round_idx <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        h_cap     <= work_t'(bus.hash_in);
                        work      <= work_t'(bus.hash_in);
                        round_idx <= '0;
                        for (int i = 0; i < 16; i++) w[i] <= bus.block_in[511 - 32*i -: 32];
                    end
                end
                ROUND: begin
                    work <= work_nx;
                    for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
                    w[15]     <= w_new;
                    round_idx <= last_round ? 6'd0 : round_idx + 6'd1;
                end
                FINAL: begin
                    digest_q <= add_work(h_cap, work);
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
